// File: rtl/serial_work_transmit.sv
// Serialises one 704-bit work packet {data, nonce, target0, target1} as 8N1 UART bytes, MSB byte first.
// Optional: define SERIAL_WORK_TX_CHECKSUM_EN to append an XOR checksum byte (89 bytes total).
module serial_work_transmit #(
  parameter int CLK_HZ   = 20_000_000,
  parameter int BAUD     = 115_200,
  parameter int GAP_BITS = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [607:0] data,
  input  logic [31:0]  nonce,
  input  logic [31:0]  target0,
  input  logic [31:0]  target1,
  output logic         TxD,
  output logic         busy,
  output logic         done
);
  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] DIV_M1 = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    GAP_M1 = 4'(GAP_BITS - 1);
`ifdef SERIAL_WORK_TX_CHECKSUM_EN
  localparam logic [6:0] LAST_BYTE = 7'd88;
`else
  localparam logic [6:0] LAST_BYTE = 7'd87;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP, S_DONE} state_t;
  state_t state, state_n;

  logic [703:0]  sh;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [3:0]    gap_cnt;
  logic [6:0]    byte_cnt;
  logic [7:0]    cur_byte;
  logic          bit_end, last;

  assign bit_end = (baud_cnt == DIV_M1);
  assign last    = (byte_cnt == LAST_BYTE);

`ifdef SERIAL_WORK_TX_CHECKSUM_EN
  logic [7:0] csum;
  assign cur_byte = (byte_cnt == 7'd88) ? csum : sh[703:696];

  always_ff @(posedge clk) begin
    if (rst)
      csum <= '0;
    else if (state == S_IDLE && start)
      csum <= '0;
    else if (state == S_STOP && bit_end && byte_cnt != 7'd88)
      csum <= csum ^ cur_byte;
  end
`else
  assign cur_byte = sh[703:696];
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_START;
      S_START: if (bit_end) state_n = S_DATA;
      S_DATA:  if (bit_end && bit_cnt == 3'd7) state_n = S_STOP;
      S_STOP:
        if (bit_end) begin
          if (GAP_BITS != 0) state_n = S_GAP;
          else               state_n = last ? S_DONE : S_START;
        end
      S_GAP:   if (bit_end && gap_cnt == GAP_M1) state_n = last ? S_DONE : S_START;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    TxD = 1'b1;
    case (state)
      S_START: TxD = 1'b0;
      S_DATA:  TxD = cur_byte[bit_cnt];
      default: TxD = 1'b1;
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sh       <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE || state == S_DONE || bit_end) baud_cnt <= '0;
      else                                               baud_cnt <= baud_cnt + 1'b1;
      if (state == S_IDLE && start) begin
        sh       <= {data, nonce, target0, target1};
        bit_cnt  <= '0;
        gap_cnt  <= '0;
        byte_cnt <= '0;
      end
      if (state == S_DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;
      if (state == S_GAP && bit_end) gap_cnt <= (gap_cnt == GAP_M1) ? 4'd0 : gap_cnt + 1'b1;
      // byte_cnt holds at the last byte so the trailing gap still sees it as last
      if (state == S_STOP && bit_end) begin
        sh <= {sh[695:0], 8'h00};
        if (!last) byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_work_transmit.sv
// Self-checking bench: per-cycle expected line from a byte-stream model plus mid-bit UART decoding.
module tb_serial_work_transmit;
  localparam int DIV = 10;
`ifdef SERIAL_WORK_TX_CHECKSUM_EN
  localparam int NB = 89;
`else
  localparam int NB = 88;
`endif
  localparam int LEN = NB * 10 * DIV;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [607:0] data = '0;
  logic [31:0] nonce = '0, target0 = '0, target1 = '0;
  logic TxD, busy, done;
  int checks = 0, failures = 0;

  serial_work_transmit #(.CLK_HZ(1_000_000), .BAUD(100_000), .GAP_BITS(0)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data), .nonce(nonce),
    .target0(target0), .target1(target1), .TxD(TxD), .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [703:0] rand_pkt();
    logic [703:0] p;
    for (int i = 0; i < 22; i++) p[32*i +: 32] = $urandom;
    return p;
  endfunction

  task automatic drive(input logic [703:0] p);
    {data, nonce, target0, target1} = p;
  endtask

  // Drives one packet and gathers statistics; scenario tasks judge them.
  task automatic run_packet(input logic [703:0] p, input bit pre, input int abort_at,
                            input bit guard, input bit chain, input logic [703:0] pnext,
                            output int bad_tx, output int bad_busy, output int dones,
                            output int done_at, output int bad_bytes, output logic [7:0] b0);
    logic [7:0] eb [89];
    logic [7:0] dec [89];
    logic [7:0] cs;
    logic exp;
    int k, bi, last;
    cs = 8'h00;
    for (int j = 0; j < 88; j++) begin
      eb[j] = p[703-8*j -: 8];
      cs ^= eb[j];
    end
    eb[88] = cs;
    for (int j = 0; j < 89; j++) dec[j] = 8'h00;
    bad_tx = 0; bad_busy = 0; dones = 0; done_at = -1; bad_bytes = 0;
    if (!pre) begin
      @(negedge clk); drive(p); start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    drive(rand_pkt());
    last = chain ? LEN + 1 : LEN + 20;
    for (int n = 0; n <= last; n++) begin
      k  = n / (10 * DIV);
      bi = (n % (10 * DIV)) / DIV;
      if (n >= LEN)     exp = 1'b1;
      else if (bi == 0) exp = 1'b0;
      else if (bi == 9) exp = 1'b1;
      else              exp = eb[k][bi-1];
      if (TxD !== exp) bad_tx++;
      if (busy !== 1'(n < LEN)) bad_busy++;
      if (done === 1'b1) begin dones++; done_at = n; end
      else if (done !== 1'b0) dones += 100;
      if (n < LEN && n % DIV == DIV / 2 && bi >= 1 && bi <= 8) dec[k][bi-1] = TxD;
      if (n == abort_at) begin rst = 1'b1; break; end
      if (guard && n == 2000) begin drive(rand_pkt()); start = 1'b1; end
      if (guard && n == 2001) start = 1'b0;
      if (chain && n == LEN) begin drive(rand_pkt()); start = 1'b1; end
      if (chain && n == LEN + 1) begin drive(pnext); start = 1'b1; end
      @(negedge clk);
    end
    for (int j = 0; j < NB; j++) if (dec[j] !== eb[j]) bad_bytes++;
    b0 = dec[0];
  endtask

  task automatic test_reset();
    int edges, active;
    logic prev;
    rst = 1'b1; start = 1'b1; drive(rand_pkt());
    repeat (3) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++; if (TxD !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b exp=1", TxD); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    edges = 0; active = 0; prev = TxD;
    repeat (100) begin
      @(negedge clk);
      if (TxD !== prev) edges++;
      prev = TxD;
      if (busy !== 1'b0 || done !== 1'b0) active++;
    end
    checks++; if (edges != 0) begin failures++; $display("FAIL reset_idle_edges got=%0d exp=0", edges); end
    checks++; if (active != 0) begin failures++; $display("FAIL reset_idle_active got=%0d exp=0", active); end
  endtask

  task automatic test_framing();
    logic [703:0] p;
    int bt, bb, dn, da, by;
    logic [7:0] b0;
    p = rand_pkt(); p[703:696] = 8'hA5;
    run_packet(p, 0, -1, 0, 0, '0, bt, bb, dn, da, by, b0);
    checks++; if (b0 !== 8'hA5) begin failures++; $display("FAIL framing_byte0 got=%h exp=a5", b0); end
    checks++; if (bt != 0) begin failures++; $display("FAIL framing_line got=%0d bad cycles exp=0", bt); end
    checks++; if (bb != 0) begin failures++; $display("FAIL framing_busy got=%0d bad cycles exp=0", bb); end
  endtask

  task automatic test_full_packet();
    logic [703:0] p;
    int bt, bb, dn, da, by;
    logic [7:0] b0;
    for (int i = 0; i < 76; i++) p[703-8*i -: 8] = 8'(i + 1);
    p[95:0] = {32'hDEADBEEF, 32'h0000FFFF, 32'h12345678};
    run_packet(p, 0, -1, 0, 0, '0, bt, bb, dn, da, by, b0);
    checks++; if (bt != 0) begin failures++; $display("FAIL full_line got=%0d bad cycles exp=0", bt); end
    checks++; if (by != 0) begin failures++; $display("FAIL full_bytes got=%0d bad bytes exp=0", by); end
    checks++; if (dn != 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", dn); end
    checks++; if (da != LEN) begin failures++; $display("FAIL full_done_at got=%0d exp=%0d", da, LEN); end
    checks++; if (bb != 0) begin failures++; $display("FAIL full_busy got=%0d bad cycles exp=0", bb); end
  endtask

  task automatic test_busy_guard();
    int bt, bb, dn, da, by;
    logic [7:0] b0;
    run_packet(rand_pkt(), 0, -1, 1, 0, '0, bt, bb, dn, da, by, b0);
    checks++; if (bt != 0) begin failures++; $display("FAIL guard_line got=%0d bad cycles exp=0", bt); end
    checks++; if (by != 0) begin failures++; $display("FAIL guard_bytes got=%0d bad bytes exp=0", by); end
    checks++; if (dn != 1) begin failures++; $display("FAIL guard_done_count got=%0d exp=1", dn); end
  endtask

  task automatic test_reset_mid();
    int bt, bb, dn, da, by, bad;
    logic [7:0] b0;
    run_packet(rand_pkt(), 0, 455, 0, 0, '0, bt, bb, dn, da, by, b0);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (TxD !== 1'b1) begin failures++; $display("FAIL abort_txd got=%b exp=1", TxD); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (dn != 0 || done !== 1'b0) begin failures++; $display("FAIL abort_done got=%0d/%b exp=0/0", dn, done); end
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (TxD !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL abort_quiet got=%0d bad cycles exp=0", bad); end
    run_packet(rand_pkt(), 0, -1, 0, 0, '0, bt, bb, dn, da, by, b0);
    checks++; if (bt != 0 || by != 0) begin failures++; $display("FAIL abort_fresh got=%0d/%0d exp=0/0", bt, by); end
    checks++; if (da != LEN || dn != 1) begin failures++; $display("FAIL abort_fresh_done got=%0d@%0d exp=1@%0d", dn, da, LEN); end
  endtask

  task automatic test_checksum();
    logic [703:0] p;
    int bt, bb, dn, da, by, exp_at;
    logic [7:0] b0;
`ifdef SERIAL_WORK_TX_CHECKSUM_EN
    exp_at = 8900;
`else
    exp_at = 8800;
`endif
    p = '0; p[31:0] = 32'h000000FF;
    run_packet(p, 0, -1, 0, 0, '0, bt, bb, dn, da, by, b0);
    checks++; if (da != exp_at) begin failures++; $display("FAIL csum_done_at got=%0d exp=%0d", da, exp_at); end
    checks++; if (bt != 0) begin failures++; $display("FAIL csum_line got=%0d bad cycles exp=0", bt); end
  endtask

  task automatic test_back_to_back();
    logic [703:0] pa, pb;
    int bt, bb, dn, da, by;
    logic [7:0] b0;
    pa = rand_pkt(); pb = rand_pkt();
    run_packet(pa, 0, -1, 0, 1, pb, bt, bb, dn, da, by, b0);
    checks++; if (bt != 0 || dn != 1) begin failures++; $display("FAIL b2b_first got=%0d/%0d exp=0/1", bt, dn); end
    run_packet(pb, 1, -1, 0, 0, '0, bt, bb, dn, da, by, b0);
    checks++; if (bt != 0 || by != 0) begin failures++; $display("FAIL b2b_second got=%0d/%0d exp=0/0", bt, by); end
    checks++; if (da != LEN || bb != 0) begin failures++; $display("FAIL b2b_second_timing got=%0d/%0d exp=%0d/0", da, bb, LEN); end
  endtask

  initial begin
    test_reset();
    test_framing();
    test_full_packet();
    test_busy_guard();
    test_reset_mid();
    test_checksum();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
